// File: rtl/program_dumper_pkg.sv
// Shared processor package: dumper state encoding, default memory geometry,
// and the program loader's framing constants.
package program_dumper_pkg;

  // Default memory geometry shared by the loader and the dumper
  localparam int DUMP_ADDR_WIDTH = 5;
  localparam int DUMP_DATA_WIDTH = 16;

  // Program loader constants (the loader writes the memory the dumper reads back)
  localparam int              LOADER_ADDR_WIDTH = DUMP_ADDR_WIDTH;
  localparam int              LOADER_DATA_WIDTH = DUMP_DATA_WIDTH;
  localparam logic [7:0]      LOADER_SYNC_BYTE  = 8'hA5;
  localparam int              LOADER_BYTES_PER_WORD = DUMP_DATA_WIDTH / 8;

  // Dumper FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

endpackage : program_dumper_pkg

// File: rtl/program_dumper.sv
// Program dumper: reads words 0..N-1 from an external synchronous memory and
// streams each one out over a valid/ready interface, one word in flight at a time.
module program_dumper
  import program_dumper_pkg::*;
#(
  parameter int ADDR_WIDTH = DUMP_ADDR_WIDTH,
  parameter int DATA_WIDTH = DUMP_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_dump,
  input  logic [ADDR_WIDTH:0]   dump_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  dump_complete
);

  // A full memory's worth of words; also the value a zero count maps to
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_LEFT   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  dump_state_e           r_state;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_read;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ADDR_WIDTH-1:0] r_out_addr;
  logic                  r_out_valid;
  logic                  r_busy;
  logic                  r_dump_complete;

  logic [ADDR_WIDTH:0]   w_start_count;
  logic                  w_handshake;
  logic                  w_more_words;

  // Zero means a full dump; anything larger than the memory is clamped so
  // the read address can never wrap past the top word.
  assign w_start_count = ((dump_count == '0) || (dump_count > FULL_COUNT))
                         ? FULL_COUNT : dump_count;
  assign w_handshake   = r_out_valid & out_ready;
  assign w_more_words  = (r_remaining > ONE_LEFT);

  // Dump sequencer: every output is a register updated alongside the state
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order in this block.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_remaining     <= '0;
      r_mem_addr      <= '0;
      r_mem_read      <= 1'b0;
      r_out_data      <= '0;
      r_out_addr      <= '0;
      r_out_valid     <= 1'b0;
      r_busy          <= 1'b0;
      r_dump_complete <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_dump) begin
            r_remaining     <= w_start_count;
            r_mem_addr      <= '0;
            r_dump_complete <= 1'b0;
            r_mem_read      <= 1'b1;
            r_busy          <= 1'b1;
            r_state         <= ST_READ;
          end
        end

        // Single-cycle read strobe; memory returns data during WAIT
        ST_READ: begin
          r_mem_read <= 1'b0;
          r_state    <= ST_WAIT;
        end

        ST_WAIT: begin
          r_out_data  <= mem_read_data;
          r_out_addr  <= r_mem_addr;
          r_out_valid <= 1'b1;
          r_state     <= ST_SEND;
        end

        // Word and address hold still until the downstream accepts them
        ST_SEND: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_remaining <= r_remaining - ONE_LEFT;
            if (w_more_words) begin
              r_mem_addr <= r_mem_addr + 1'b1;
              r_mem_read <= 1'b1;
              r_state    <= ST_READ;
            end else begin
              r_busy          <= 1'b0;
              r_dump_complete <= 1'b1;
              r_state         <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_mem_read  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr      = r_mem_addr;
  assign mem_read      = r_mem_read;
  assign out_data      = r_out_data;
  assign out_addr      = r_out_addr;
  assign out_valid     = r_out_valid;
  assign busy          = r_busy;
  assign dump_complete = r_dump_complete;

endmodule : program_dumper
